// File: rtl/pit_timer_core.sv
// pit_timer_core: PIT control/status and modulus registers, 2^N prescaler,
// 16-bit modulus counter, rollover flag and interrupt source.
module pit_timer_core #(
  parameter int DWIDTH = 16
) (
  input  logic              wb_clk_i,
  input  logic              async_rst_b,
  input  logic              sync_reset,
  input  logic [DWIDTH-1:0] wb_dat_i,
  input  logic [3:0]        write_regs,
  output logic [47:0]       read_regs,
  output logic              irq_source,
  output logic              pit_o
);

  logic [15:0] ctrl_r, ctrl_next_s;
  logic [15:0] mod_r, mod_next_s;
  logic [15:0] cnt_r, cnt_next_s;
  logic [14:0] presc_r, presc_next_s;
  logic        pit_r, pit_next_s;
  logic [7:0]  lo_byte_s, hi_byte_s;
  logic [14:0] mask_s;
  logic [15:0] term_s;
  logic        tick_s, rollover_s, mod_wr_s, ena_fall_s, restart_s, flag_next_s;

  assign lo_byte_s = wb_dat_i[7:0];

  // A byte-wide bus drives every register byte from the same lane.
  generate
    if (DWIDTH == 16) begin : g_word
      assign hi_byte_s = wb_dat_i[DWIDTH-1:8];
    end else begin : g_byte
      assign hi_byte_s = wb_dat_i[7:0];
    end
  endgenerate

  // Timing engine and register next-state logic.
  always_comb begin
    mask_s       = ~(15'h7FFF << ctrl_r[11:8]);
    term_s       = mod_r - 16'd1;
    mod_wr_s     = write_regs[2] | write_regs[3];
    ena_fall_s   = write_regs[0] & ctrl_r[0] & ~lo_byte_s[0];
    restart_s    = ~ctrl_r[0] | mod_wr_s | ena_fall_s;
    tick_s       = ctrl_r[0] & ((presc_r & mask_s) == mask_s);
    rollover_s   = tick_s & (cnt_r == term_s) & ~mod_wr_s;
    pit_next_s   = rollover_s;

    if (restart_s) begin
      presc_next_s = 15'd0;
    end else begin
      presc_next_s = presc_r + 15'd1;
    end

    if (restart_s || rollover_s) begin
      cnt_next_s = 16'd0;
    end else if (tick_s) begin
      cnt_next_s = cnt_r + 16'd1;
    end else begin
      cnt_next_s = cnt_r;
    end

    // Hardware set beats a simultaneous write-1 clear.
    if (rollover_s) begin
      flag_next_s = 1'b1;
    end else if (write_regs[0] && lo_byte_s[2]) begin
      flag_next_s = 1'b0;
    end else begin
      flag_next_s = ctrl_r[2];
    end

    ctrl_next_s = ctrl_r;
    if (write_regs[0]) begin
      ctrl_next_s[7:0] = lo_byte_s & 8'h03;
    end else begin
      ctrl_next_s[7:0] = ctrl_r[7:0];
    end
    if (write_regs[1]) begin
      ctrl_next_s[15:8] = hi_byte_s & 8'h0F;
    end else begin
      ctrl_next_s[15:8] = ctrl_r[15:8];
    end
    ctrl_next_s[2] = flag_next_s;

    mod_next_s = mod_r;
    if (write_regs[2]) begin
      mod_next_s[7:0] = lo_byte_s;
    end else begin
      mod_next_s[7:0] = mod_r[7:0];
    end
    if (write_regs[3]) begin
      mod_next_s[15:8] = hi_byte_s;
    end else begin
      mod_next_s[15:8] = mod_r[15:8];
    end
  end

  // State registers with asynchronous and synchronous reset.
  always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
    if (!async_rst_b) begin
      ctrl_r  <= 16'h0000;
      mod_r   <= 16'h0000;
      cnt_r   <= 16'h0000;
      presc_r <= 15'h0000;
      pit_r   <= 1'b0;
    end else if (sync_reset) begin
      ctrl_r  <= 16'h0000;
      mod_r   <= 16'h0000;
      cnt_r   <= 16'h0000;
      presc_r <= 15'h0000;
      pit_r   <= 1'b0;
    end else begin
      ctrl_r  <= ctrl_next_s;
      mod_r   <= mod_next_s;
      cnt_r   <= cnt_next_s;
      presc_r <= presc_next_s;
      pit_r   <= pit_next_s;
    end
  end

  assign read_regs  = {cnt_r, mod_r, ctrl_r};
  assign irq_source = ctrl_r[2] & ctrl_r[1];
  assign pit_o      = pit_r;

endmodule

// File: tb/tb_pit_timer_core.sv
// Directed bench for pit_timer_core: a word-bus instance and a byte-bus instance
// share clock and resets; expected values are hand-computed cycle counts.
module tb_pit_timer_core;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        srst;
  logic [15:0] dat_a;
  logic [3:0]  wr_a;
  logic [47:0] rd_a;
  logic        irq_a, pit_a;
  logic [7:0]  dat_b;
  logic [3:0]  wr_b;
  logic [47:0] rd_b;
  logic        irq_b, pit_b;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pit_timer_core #(.DWIDTH(16)) u_dut_a (
    .wb_clk_i(clk), .async_rst_b(rst_b), .sync_reset(srst), .wb_dat_i(dat_a),
    .write_regs(wr_a), .read_regs(rd_a), .irq_source(irq_a), .pit_o(pit_a)
  );

  pit_timer_core #(.DWIDTH(8)) u_dut_b (
    .wb_clk_i(clk), .async_rst_b(rst_b), .sync_reset(srst), .wb_dat_i(dat_b),
    .write_regs(wr_b), .read_regs(rd_b), .irq_source(irq_b), .pit_o(pit_b)
  );

  task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled on the following posedge.
  task automatic write_a(input logic [3:0] stb, input logic [15:0] d);
    wr_a  = stb;
    dat_a = d;
    @(negedge clk);
    wr_a  = 4'b0000;
    dat_a = 16'h0000;
  endtask

  task automatic write_b(input logic [3:0] stb, input logic [7:0] d);
    wr_b  = stb;
    dat_b = d;
    @(negedge clk);
    wr_b  = 4'b0000;
    dat_b = 8'h00;
  endtask

  task automatic sync_clear();
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check_eq("srst_a", rd_a, 48'h0);
    check_eq("srst_b", rd_b, 48'h0);
  endtask

  initial begin
    rst_b = 1'b0;
    srst  = 1'b0;
    dat_a = 16'h0000;
    wr_a  = 4'b0000;
    dat_b = 8'h00;
    wr_b  = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("rst_regs", rd_a, 48'h0);
    check_eq("rst_pit", {47'h0, pit_a}, 48'h0);
    check_eq("rst_irq", {47'h0, irq_a}, 48'h0);
    rst_b = 1'b1;

    // Modulus 4, PRE=0: counts 0..3; reserved CTRL bits are dropped.
    write_a(4'b1100, 16'h0004);
    write_a(4'b0011, 16'hF0F9);
    check_eq("t1_ctrl", {32'h0, rd_a[15:0]}, 48'h0001);
    check_eq("t1_mod", {32'h0, rd_a[31:16]}, 48'h0004);
    check_eq("t1_cnt0", {32'h0, rd_a[47:32]}, 48'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("t1_cnt%0d", i), {32'h0, rd_a[47:32]}, 48'(i % 4));
      check_eq($sformatf("t1_pit%0d", i), {47'h0, pit_a}, 48'((i % 4) == 0));
      check_eq($sformatf("t1_irq%0d", i), {47'h0, irq_a}, 48'h0);
    end
    check_eq("t1_flag", {32'h0, rd_a[15:0]}, 48'h0005);

    // PRE=2, MOD=3, IRQE: rollover every 12 clocks.
    sync_clear();
    write_a(4'b1100, 16'h0003);
    write_a(4'b0011, 16'h0203);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check_eq($sformatf("t2_pit%0d", i), {47'h0, pit_a}, 48'(i == 12));
      check_eq($sformatf("t2_irq%0d", i), {47'h0, irq_a}, 48'(i == 12));
    end
    write_a(4'b0011, 16'h0207);
    check_eq("t2_irq_clr", {47'h0, irq_a}, 48'h0);
    check_eq("t2_ctrl_clr", {32'h0, rd_a[15:0]}, 48'h0203);
    repeat (10) @(negedge clk);
    check_eq("t2_cnt23", {32'h0, rd_a[47:32]}, 48'h0002);
    // Flag clear lands on the rollover edge.
    write_a(4'b0011, 16'h0207);
    check_eq("t3_pit", {47'h0, pit_a}, 48'h1);
    check_eq("t3_ctrl", {32'h0, rd_a[15:0]}, 48'h0207);
    check_eq("t3_irq", {47'h0, irq_a}, 48'h1);
    @(negedge clk);
    check_eq("t3_pit_end", {47'h0, pit_a}, 48'h0);

    // Modulus 0 means a 65536-count period.
    sync_clear();
    write_a(4'b1100, 16'h0000);
    write_a(4'b0011, 16'h0001);
    repeat (65535) @(negedge clk);
    check_eq("t4_cnt_ffff", {32'h0, rd_a[47:32]}, 48'hFFFF);
    check_eq("t4_pit_early", {47'h0, pit_a}, 48'h0);
    @(negedge clk);
    check_eq("t4_pit", {47'h0, pit_a}, 48'h1);
    check_eq("t4_cnt_wrap", {32'h0, rd_a[47:32]}, 48'h0);

    // Byte bus: PRE=2, ENA, MOD=5 -> 20-clock period from the MOD write.
    sync_clear();
    write_b(4'b0010, 8'h02);
    write_b(4'b0001, 8'h01);
    write_b(4'b0100, 8'h05);
    check_eq("t5_ctrl", {32'h0, rd_b[15:0]}, 48'h0201);
    check_eq("t5_mod", {32'h0, rd_b[31:16]}, 48'h0005);
    check_eq("t5_cnt0", {32'h0, rd_b[47:32]}, 48'h0);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      check_eq($sformatf("t5_pit%0d", j), {47'h0, pit_b}, 48'((j == 20) || (j == 40)));
      if (j == 19) check_eq("t5_cnt19", {32'h0, rd_b[47:32]}, 48'h0004);
    end
    check_eq("t5_irq", {47'h0, irq_b}, 48'h0);

    // Async reset mid-count with FLAG set.
    sync_clear();
    write_a(4'b1100, 16'h0004);
    write_a(4'b0011, 16'h0003);
    repeat (6) @(negedge clk);
    check_eq("t6_cnt2", {32'h0, rd_a[47:32]}, 48'h0002);
    check_eq("t6_ctrl", {32'h0, rd_a[15:0]}, 48'h0007);
    check_eq("t6_irq_pre", {47'h0, irq_a}, 48'h1);
    #2 rst_b = 1'b0;
    #1;
    check_eq("t6_regs", rd_a, 48'h0);
    check_eq("t6_pit", {47'h0, pit_a}, 48'h0);
    check_eq("t6_irq", {47'h0, irq_a}, 48'h0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t6_idle_regs", rd_a, 48'h0);
    check_eq("t6_idle_pit", {47'h0, pit_a}, 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
